unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
// - Shares one single-port synchronous BRAM (1-cycle read latency) between the IF-stage fetch port and the MEM-stage data port.
// - Fixed data priority with a starvation counter that forces a fetch grant after STARVE_MAX consecutive denials.
// - Routes each read response back to its owner one cycle after grant. The pipeline uses a low if_gnt as its fetch stall.
// PARAMETERS
// - ADDR_W      10  word-address width of the shared memory
// - DATA_W      32  data width; byte-enable width is DATA_W/8
// - STARVE_MAX  4   consecutive fetch denials before fetch wins; legal range 1..15
// PORTS
// - clk        in   1         clock, rising edge
// - rst        in   1         asynchronous, active-high reset
// - if_req     in   1         fetch read request
// - if_addr    in   ADDR_W    fetch word address
// - if_gnt     out  1         fetch accepted this cycle
// - if_rvalid  out  1         fetch read data valid
// - if_rdata   out  DATA_W    fetch read data
// - d_req      in   1         data request
// - d_we       in   1         1 = write, 0 = read
// - d_addr     in   ADDR_W    data word address
// - d_wdata    in   DATA_W    write data
// - d_be       in   DATA_W/8  write byte enables
// - d_gnt      out  1         data request accepted this cycle
// - d_rvalid   out  1         data read data valid
// - d_rdata    out  DATA_W    data read data
// - mem_en     out  1         BRAM enable
// - mem_we     out  DATA_W/8  BRAM byte write enables
// - mem_addr   out  ADDR_W    BRAM address
// - mem_wdata  out  DATA_W    BRAM write data
// - mem_rdata  in   DATA_W    BRAM read data, valid one cycle after mem_en
// BEHAVIOUR
// - Grants are combinational from the current inputs and the registered starve_cnt.
//   - fetch_pri = (starve_cnt == STARVE_MAX)
//   - d_gnt  = d_req & ~(if_req & fetch_pri)
//   - if_gnt = if_req & ~d_gnt
// - Requesters hold req, addr, wdata and be stable until gnt. The arbiter latches nothing before the grant.
// - Memory drive:
//   - Granted access drives mem_en=1 and mem_addr from the granted port.
//   - mem_we = d_be only for a granted data write, else 0. mem_wdata = d_wdata.
//   - No grant: all mem_* outputs are 0.
// - starve_cnt, width $clog2(STARVE_MAX+1), updates on the clock edge:
//   - clears to 0 if ~if_req or if_gnt;
//   - else increments, saturating at STARVE_MAX.
// - Responses:
//   - A read granted in cycle N sets the owner register (OWN_IF or OWN_D); in cycle N+1 that port's rvalid=1 and its rdata = mem_rdata.
//   - Writes set OWN_NONE. A write with d_be==0 is still granted but modifies nothing and returns no rvalid.
//   - rdata is forced to 0 whenever the port's rvalid is 0.
// - Full throughput: one access per cycle, back-to-back grants allowed. A new grant may coincide with the previous response.
// - Reset (async, active-high): starve_cnt=0 and owner=OWN_NONE immediately.
//   - Hence if_rvalid=d_rvalid=0 and if_rdata=d_rdata=0.
//   - Grants and mem_* stay a combinational function of the inputs with starve_cnt=0, so data has priority.
//   - An in-flight response is dropped, not replayed.
//   - The pipeline holds its requesters idle while rst=1.
// STRUCTURE
// - Package cpu_mem_pkg:
//   - owner enum OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2;
//   - DATA_W and BE_W constants, shared with the DMEM and IMEM wrappers.
// - One sub-module, arb_starve_ctr: saturating counter with inputs inc and clr, outputs cnt and at_max (at_max = fetch_pri).
// - Top level holds the grant logic, mem_* muxing and owner register.
// TESTING
// - Fetch only: if_req=1 at addrs 0x000..0x003 on consecutive cycles.
//   -> if_gnt=1 every cycle; if_rvalid=1 one cycle later with the preloaded words; d_rvalid stays 0.
// - Write then read: d_we=1, addr 0x020, wdata 0xDEADBEEF, be 4'hF; next cycle d_we=0 on the same addr.
//   -> mem_we=4'hF on the write; d_rvalid=1, d_rdata=0xDEADBEEF on the cycle after the read grant.
// - Byte write: be 4'b0100, wdata 0x00AB0000 onto 0xDEADBEEF, then read back -> 0xDEABBEEF.
// - Contention, STARVE_MAX=4, both requests held high from cycle 0.
//   -> d_gnt in cycles 0-3, if_gnt in cycle 4, d_gnt in 5-8, if_gnt in 9; never both grants in one cycle.
// - Starvation cleared: fetch is denied 3 cycles, if_req drops for 1 cycle and then returns.
//   -> starve_cnt=0; fetch waits 4 more denials before it wins.
// - Reset mid-read: rst pulses in the cycle after a data read grant.
//   -> d_rvalid=0 and d_rdata=0 with no clock edge; starve_cnt=0; after release, d_req+if_req gives d_gnt=1.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared memory-subsystem types and widths.
// Provides the response-owner encoding used by the unified arbiter and the
// data/byte-enable widths shared with the DMEM and IMEM wrappers.
package cpu_mem_pkg;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating fetch-starvation counter.
// Ports: clk/rst (async active-high); inc counts one denial; clr restarts the
// count and wins over inc; cnt is the current count; at_max flags cnt == MAX.
module arb_starve_ctr #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);
    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port 1-cycle-latency BRAM between
// the fetch port (if_*) and the data port (d_*).
// Ports: if_req/if_addr -> if_gnt, if_rvalid/if_rdata (fetch read port);
// d_req/d_we/d_addr/d_wdata/d_be -> d_gnt, d_rvalid/d_rdata (data port);
// mem_en/mem_we/mem_addr/mem_wdata -> BRAM, mem_rdata <- BRAM.
// Data has fixed priority until fetch has been denied STARVE_MAX cycles in a
// row; read data returns to its owner the cycle after the grant.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    import cpu_mem_pkg::*;

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          fetch_pri;
    owner_e        owner, owner_nxt;

    // Counts only cycles where fetch asks and loses; any gap or win restarts it.
    arb_starve_ctr #(.MAX(STARVE_MAX), .W(CW)) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (if_req & ~if_gnt),
        .clr    (~if_req | if_gnt),
        .cnt    (starve_cnt),
        .at_max (fetch_pri)
    );

    assign d_gnt     = d_req & ~(if_req & fetch_pri);
    assign if_gnt    = if_req & ~d_gnt;
    assign mem_en    = d_gnt | if_gnt;
    assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    assign mem_we    = (d_gnt & d_we) ? d_be : '0;
    assign mem_wdata = mem_en ? d_wdata : '0;

    // Writes never produce a response, so they leave no owner behind.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (d_gnt)
            owner_nxt = d_we ? OWN_NONE : OWN_D;
        else if (if_gnt)
            owner_nxt = OWN_IF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            owner <= OWN_NONE;
        else
            owner <= owner_nxt;
    end

    assign if_rvalid = (owner == OWN_IF);
    assign d_rvalid  = (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench for unified_mem_arbiter with a
// behavioural 1-cycle-latency BRAM and a reference memory/starvation model.
module tb_unified_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] bram    [1024];
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] q_if[$];
    logic [DW-1:0] q_d[$];
    logic          pend_if = 1'b0, pend_d = 1'b0;
    int            cnt_m = 0;
    logic          g_if, g_d;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < BW; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= bram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: grants, BRAM drive and responses checked every cycle.
    always @(negedge clk) begin
        logic e_d, e_if;
        if (rst) begin
            pend_if = 1'b0;
            pend_d  = 1'b0;
            q_if.delete();
            q_d.delete();
            cnt_m = 0;
        end else begin
            e_d  = d_req & ~(if_req & (cnt_m == SM));
            e_if = if_req & ~e_d;
            check("d_gnt", DW'(d_gnt), DW'(e_d));
            check("if_gnt", DW'(if_gnt), DW'(e_if));
            check("both_gnt", DW'(d_gnt & if_gnt), '0);
            check("starve_cnt", DW'(dut.starve_cnt), DW'(cnt_m));
            check("mem_en", DW'(mem_en), DW'(e_d | e_if));
            check("mem_addr", DW'(mem_addr), e_d ? DW'(d_addr) : (e_if ? DW'(if_addr) : '0));
            check("mem_we", DW'(mem_we), (e_d & d_we) ? DW'(d_be) : '0);
            check("mem_wdata", mem_wdata, (e_d | e_if) ? d_wdata : '0);
            check("if_rvalid", DW'(if_rvalid), DW'(pend_if));
            check("if_rdata", if_rdata, (pend_if && q_if.size() > 0) ? q_if.pop_front() : '0);
            check("d_rvalid", DW'(d_rvalid), DW'(pend_d));
            check("d_rdata", d_rdata, (pend_d && q_d.size() > 0) ? q_d.pop_front() : '0);
            if (e_d & d_we)
                for (int b = 0; b < BW; b++)
                    if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
            pend_if = e_if;
            pend_d  = e_d & ~d_we;
            if (e_if) q_if.push_back(ref_mem[if_addr]);
            if (pend_d) q_d.push_back(ref_mem[d_addr]);
            cnt_m = (~if_req | e_if) ? 0 : ((cnt_m == SM) ? SM : cnt_m + 1);
        end
    end

    task automatic set_in(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                          input logic [AW-1:0] da, input logic [DW-1:0] dwd, input logic [BW-1:0] dbe);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_be    = dbe;
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                         input logic [AW-1:0] da, input logic [DW-1:0] dwd, input logic [BW-1:0] dbe);
        set_in(ir, ia, dr, dwe, da, dwd, dbe);
        #3;
        g_if = if_gnt;
        g_d  = d_gnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] hist;
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = (i * 32'h01010101) ^ 32'hC0DE0000;
            ref_mem[i] = (i * 32'h01010101) ^ 32'hC0DE0000;
        end
        rst = 1'b1;
        set_in(0, '0, 0, 0, '0, '0, '0);
        #2;
        check("rst_if_rvalid", DW'(if_rvalid), '0);
        check("rst_d_rvalid", DW'(d_rvalid), '0);
        check("rst_if_rdata", if_rdata, '0);
        check("rst_d_rdata", d_rdata, '0);
        check("rst_starve", DW'(dut.starve_cnt), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, '0, 0, 0, '0, '0, '0);
        // fetch only
        for (int i = 0; i < 4; i++) drive(1, AW'(i), 0, 0, '0, '0, '0);
        // write, read, byte write, read, zero-be write, read
        drive(0, '0, 1, 1, 10'h020, 32'hDEADBEEF, 4'hF);
        drive(0, '0, 1, 0, 10'h020, '0, '0);
        drive(0, '0, 1, 1, 10'h020, 32'h00AB0000, 4'b0100);
        drive(0, '0, 1, 0, 10'h020, '0, '0);
        drive(0, '0, 1, 1, 10'h020, 32'h12345678, 4'h0);
        drive(0, '0, 1, 0, 10'h020, '0, '0);
        check("ref_byte_merge", ref_mem[10'h020], 32'hDEABBEEF);
        drive(0, '0, 0, 0, '0, '0, '0);
        // contention
        for (int i = 0; i < 10; i++) begin
            drive(1, 10'h005, 1, 0, AW'(10'h010 + i), '0, '0);
            hist[i] = g_if;
        end
        check("contention_pattern", DW'(hist), 32'h210);
        // starvation cleared by a one-cycle gap in if_req
        for (int i = 0; i < 9; i++) begin
            drive(i != 3, 10'h006, 1, 0, 10'h030, '0, '0);
            hist[i] = g_if;
        end
        check("starve_clear_pattern", DW'(hist[8:0]), 32'h100);
        drive(0, '0, 0, 0, '0, '0, '0);
        // reset in the cycle after a data read grant
        drive(1, 10'h007, 1, 0, 10'h020, '0, '0);
        drive(1, 10'h007, 1, 0, 10'h020, '0, '0);
        set_in(1, 10'h007, 1, 0, 10'h020, '0, '0);
        #1;
        check("pre_rst_starve", DW'(dut.starve_cnt), 32'd2);
        check("pre_rst_d_rvalid", DW'(d_rvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_d_rvalid", DW'(d_rvalid), '0);
        check("mid_rst_d_rdata", d_rdata, '0);
        check("mid_rst_starve", DW'(dut.starve_cnt), '0);
        set_in(0, '0, 0, 0, '0, '0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 10'h008, 1, 0, 10'h020, '0, '0);
        check("post_rst_d_gnt", DW'(g_d), 32'd1);
        drive(0, '0, 0, 0, '0, '0, '0);
        drive(0, '0, 0, 0, '0, '0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
